// File: rtl/ex_muldiv_unit_if.sv
// Execute-stage hookup between the pipeline and the RV32M multiply/divide unit.
// The master side is the pipeline and the slave side is the unit.
interface ex_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output flush, start, op, operand_a, operand_b,
        input  stall, done, result
    );

    modport slave (
        input  flush, start, op, operand_a, operand_b,
        output stall, done, result
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit that holds the pipeline while it works.
// Build option MULDIV_FAST_MUL_EN selects a single-cycle multiplier for ops 0-3.
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    ex_muldiv_unit_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r;
    logic [2:0]          op_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [2*XLEN-1:0]   acc_r;
    logic [XLEN-1:0]     opb_r;
    logic                neg_r;
    logic                rneg_r;
    logic [XLEN-1:0]     result_r;
    logic                done_r;

    logic                sign_a_s;
    logic                sign_b_s;
    logic                a_neg_s;
    logic                b_neg_s;
    logic [XLEN-1:0]     a_abs_s;
    logic [XLEN-1:0]     b_abs_s;
    logic                div_zero_s;
    logic                div_ovf_s;
    logic [XLEN-1:0]     special_res_s;
    logic [XLEN:0]       mul_sum_s;
    logic [XLEN:0]       div_shift_s;
    logic [XLEN:0]       div_diff_s;
    logic [2*XLEN-1:0]   acc_step_s;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quot_s;
    logic [XLEN-1:0]     rem_s;
    logic [XLEN-1:0]     final_res_s;
    logic [XLEN-1:0]     fast_res_s;

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic neg);
        abs_val = neg ? -v : v;
    endfunction

    // Operand signedness per funct3
    always_comb begin
        sign_a_s = 1'b0;
        sign_b_s = 1'b0;
        case (bus.op)
            3'd1: begin sign_a_s = 1'b1; sign_b_s = 1'b1; end
            3'd2: begin sign_a_s = 1'b1; sign_b_s = 1'b0; end
            3'd4: begin sign_a_s = 1'b1; sign_b_s = 1'b1; end
            3'd6: begin sign_a_s = 1'b1; sign_b_s = 1'b1; end
            default: begin sign_a_s = 1'b0; sign_b_s = 1'b0; end
        endcase
    end

    assign a_neg_s = sign_a_s & bus.operand_a[XLEN-1];
    assign b_neg_s = sign_b_s & bus.operand_b[XLEN-1];
    assign a_abs_s = abs_val(bus.operand_a, a_neg_s);
    assign b_abs_s = abs_val(bus.operand_b, b_neg_s);

    assign div_zero_s = bus.op[2] && (bus.operand_b == {XLEN{1'b0}});
    assign div_ovf_s  = bus.op[2] && !bus.op[0]
                        && (bus.operand_a == {1'b1, {(XLEN-1){1'b0}}})
                        && (bus.operand_b == {XLEN{1'b1}});

    // Divide-by-zero and signed-overflow answers, resolved without iterating
    always_comb begin
        special_res_s = {XLEN{1'b0}};
        if (div_zero_s) begin
            special_res_s = bus.op[1] ? bus.operand_a : {XLEN{1'b1}};
        end else if (div_ovf_s) begin
            special_res_s = bus.op[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
        end else begin
            special_res_s = {XLEN{1'b0}};
        end
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    // The low half of acc starts as the multiplier/dividend and fills with product/quotient bits.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]}
                      + (acc_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
        div_shift_s = acc_r[2*XLEN-1:XLEN-1];
        div_diff_s  = div_shift_s - {1'b0, opb_r};
        if (op_r[2]) begin
            if (!div_diff_s[XLEN]) begin
                acc_step_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
            end else begin
                acc_step_s = {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_step_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end
    end

    // Sign correction and result select on the final iteration
    always_comb begin
        prod_s = neg_r  ? -acc_step_s : acc_step_s;
        quot_s = neg_r  ? -acc_step_s[XLEN-1:0] : acc_step_s[XLEN-1:0];
        rem_s  = rneg_r ? -acc_step_s[2*XLEN-1:XLEN] : acc_step_s[2*XLEN-1:XLEN];
        case (op_r)
            3'd0:    final_res_s = prod_s[XLEN-1:0];
            3'd1,
            3'd2,
            3'd3:    final_res_s = prod_s[2*XLEN-1:XLEN];
            3'd4,
            3'd5:    final_res_s = quot_s;
            3'd6,
            3'd7:    final_res_s = rem_s;
            default: final_res_s = {XLEN{1'b0}};
        endcase
    end

`ifdef MULDIV_FAST_MUL_EN
    localparam logic FAST_MUL = 1'b1;
    logic [2*XLEN-1:0] fa_s;
    logic [2*XLEN-1:0] fb_s;
    logic [2*XLEN-1:0] fast_prod_s;

    // Sign-extended full-width multiply; the low 2*XLEN bits equal the signed 33x33 product
    always_comb begin
        fa_s        = {{XLEN{a_neg_s}}, bus.operand_a};
        fb_s        = {{XLEN{b_neg_s}}, bus.operand_b};
        fast_prod_s = fa_s * fb_s;
        if (bus.op == 3'd0) begin
            fast_res_s = fast_prod_s[XLEN-1:0];
        end else begin
            fast_res_s = fast_prod_s[2*XLEN-1:XLEN];
        end
    end
`else
    localparam logic FAST_MUL = 1'b0;
    assign fast_res_s = {XLEN{1'b0}};
`endif

    // Control FSM with datapath registers; done and result are registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            op_r     <= 3'd0;
            cnt_r    <= {CNT_W{1'b0}};
            acc_r    <= {(2*XLEN){1'b0}};
            opb_r    <= {XLEN{1'b0}};
            neg_r    <= 1'b0;
            rneg_r   <= 1'b0;
            result_r <= {XLEN{1'b0}};
            done_r   <= 1'b0;
        end else if (bus.flush) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        op_r   <= bus.op;
                        cnt_r  <= {CNT_W{1'b0}};
                        acc_r  <= {{XLEN{1'b0}}, a_abs_s};
                        opb_r  <= b_abs_s;
                        neg_r  <= a_neg_s ^ b_neg_s;
                        rneg_r <= a_neg_s;
                        if (div_zero_s || div_ovf_s) begin
                            result_r <= special_res_s;
                            done_r   <= 1'b1;
                            state_r  <= DONE;
                        end else if (FAST_MUL && !bus.op[2]) begin
                            result_r <= fast_res_s;
                            done_r   <= 1'b1;
                            state_r  <= DONE;
                        end else begin
                            done_r  <= 1'b0;
                            state_r <= CALC;
                        end
                    end else begin
                        done_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    acc_r <= acc_step_s;
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == {CNT_W{1'b1}}) begin
                        result_r <= final_res_s;
                        done_r   <= 1'b1;
                        state_r  <= DONE;
                    end else begin
                        done_r  <= 1'b0;
                        state_r <= CALC;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Stall reacts to start in the same cycle so ID/EX holds the instruction
    assign bus.stall  = !bus.flush && (((state_r == IDLE) && bus.start) || (state_r == CALC));
    assign bus.done   = done_r;
    assign bus.result = result_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit; expected values are hand-computed.
module tb_ex_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic clk;
    logic reset;
    int   checks_cnt;
    int   errors_cnt;

    ex_muldiv_unit_if #(.XLEN(32)) bus ();

    ex_muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Issue one op (start dropped after the first edge), measure latency and stall cycles
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        int st;
        bit seen;
        lat = 0;
        st = 0;
        seen = 1'b0;
        bus.op = o;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.start = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (bus.stall) st++;
                @(posedge clk);
                #1;
                bus.start = 1'b0;
                lat++;
            end
        end
        check_eq({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_stall_cycles"}, st, exp_lat);
        check_eq({tag, "_result"}, bus.result, exp);
        check_eq({tag, "_stall_in_done"}, {31'd0, bus.stall}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq({tag, "_done_drops"}, {31'd0, bus.done}, 32'd0);
        check_eq({tag, "_result_held"}, bus.result, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        int d1;
        int d2;
        checks_cnt = 0;
        errors_cnt = 0;
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.operand_a = 32'd0;
        bus.operand_b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_stall", {31'd0, bus.stall}, 32'd0);
        check_eq("rst_done", {31'd0, bus.done}, 32'd0);
        check_eq("rst_result", bus.result, 32'd0);
        @(posedge clk);
        #1;

        run_op("div_m7_2",   3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, DIV_LAT);
        run_op("rem_m7_2",   3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, DIV_LAT);
        run_op("divu_by0",   3'd5, 32'd100,       32'd0,        32'hFFFF_FFFF, 1);
        run_op("remu_by0",   3'd7, 32'd100,       32'd0,        32'd100,       1);
        run_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1);
        run_op("mulh_min",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mul_min",    3'd0, 32'h8000_0000, 32'h8000_0000, 32'd0,        MUL_LAT);
        run_op("mulhsu_m1",  3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, MUL_LAT);
        run_op("mul_7_m3",   3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("divu_big",   3'd5, 32'hFFFF_FFFF, 32'd16,       32'h0FFF_FFFF, DIV_LAT);
        run_op("rem_m_neg",  3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,        DIV_LAT);

        // Flush in the tenth CALC cycle of a DIVU
        bus.op = 3'd5;
        bus.operand_a = 32'd1000;
        bus.operand_b = 32'd7;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(negedge clk);
        check_eq("flush_stall_low", {31'd0, bus.stall}, 32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) pulses++;
            if (i == 0) check_eq("flush_idle_stall", {31'd0, bus.stall}, 32'd0);
            @(posedge clk);
            #1;
        end
        check_eq("flush_no_done", pulses, 0);
        run_op("divu_after_flush", 3'd5, 32'd1000, 32'd7, 32'd142, DIV_LAT);

        // Flush in IDLE masks a simultaneous start
        bus.op = 3'd5;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        check_eq("flush_start_stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        check_eq("flush_start_idle", {31'd0, bus.stall}, 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back MULHU with start held through DONE
        bus.op = 3'd3;
        bus.operand_a = 32'hFFFF_FFFF;
        bus.operand_b = 32'hFFFF_FFFF;
        bus.start = 1'b1;
        pulses = 0;
        d1 = -10;
        d2 = -10;
        for (int i = 0; i < 2 * MUL_LAT + 10; i++) begin
            @(negedge clk);
            if (bus.done) begin
                pulses++;
                check_eq("b2b_result", bus.result, 32'hFFFF_FFFE);
                check_eq("b2b_stall_in_done", {31'd0, bus.stall}, 32'd0);
                if (pulses == 1) d1 = i;
                if (pulses == 2) d2 = i;
            end
            @(posedge clk);
            #1;
            if (i == d1 + 1) bus.start = 1'b0;
        end
        check_eq("b2b_pulses", pulses, 2);
        check_eq("b2b_first_done", d1, MUL_LAT);
        check_eq("b2b_second_done", d2, 2 * MUL_LAT + 1);

        // Reset in the middle of a divide
        bus.op = 3'd5;
        bus.operand_a = 32'd12345;
        bus.operand_b = 32'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("midrst_stall", {31'd0, bus.stall}, 32'd0);
        check_eq("midrst_done", {31'd0, bus.done}, 32'd0);
        check_eq("midrst_result", bus.result, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check_eq("midrst_no_done", pulses, 0);
        @(posedge clk);
        #1;
        run_op("divu_after_rst", 3'd5, 32'd12345, 32'd3, 32'd4115, DIV_LAT);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
